fetch_sequencer: RTL and testbench

//  Sequences the program counter and I-side memory request for the pipelined core.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_pc_target_gen.sv | 29 ++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  typedef logic [31:0] word_t;

  localparam int ADDR_W = 26;
  localparam word_t PC_STRIDE_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } fetch_state_t;

  function automatic word_t sat_inc(input word_t value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_target_gen.sv
// Redirect target selection for taken branches, jumps and register jumps.
module pc_target_gen
  import fetch_sequencer_pkg::*;
(
  input  logic              Branch,
  input  logic              Jump,
  input  logic              JR,
  input  logic [31:0]       redir_npc,
  input  logic [31:0]       bimm,
  input  logic [ADDR_W-1:0] jimm,
  input  logic [31:0]       jraddr,
  output logic [31:0]       target
);

  // JR beats Jump beats Branch when several resolve together
  always_comb begin
    target = redir_npc;
    if (JR) begin
      target = jraddr;
    end else if (Jump) begin
      target = {redir_npc[31:28], jimm, 2'b00};
    end else if (Branch) begin
      target = redir_npc + {bimm[29:0], 2'b00};
    end else begin
      target = redir_npc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencing and icache request control, including draining a wrong-path miss.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] PC_STRIDE = 32'd4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              JR,
  input  logic [31:0]       redir_npc,
  input  logic [31:0]       bimm,
  input  logic [ADDR_W-1:0] jimm,
  input  logic [31:0]       jraddr,
  output logic              imemREN,
  output logic [31:0]       imemaddr,
  output logic [31:0]       npc,
  output logic              instr_valid,
  output logic              flush,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic         halt_pend;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  drain_dest;

  assign redirect   = Branch | Jump | JR;
  assign drain_dest = redirect ? target : pend_pc;
  assign imemaddr   = pc;
  assign npc        = pc + PC_STRIDE;

  pc_target_gen u_pc_target_gen (
    .Branch    (Branch),
    .Jump      (Jump),
    .JR        (JR),
    .redir_npc (redir_npc),
    .bimm      (bimm),
    .jimm      (jimm),
    .jraddr    (jraddr),
    .target    (target)
  );

  // Handshake outputs are forced low while reset is held
  always_comb begin
    imemREN     = 1'b0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    if (!RST) begin
      imemREN     = (state != HALT);
      halted      = (state == HALT);
      flush       = redirect && (state != HALT);
      instr_valid = (state == FETCH) && !halt_req && !redirect && ihit && !stall;
    end else begin
      imemREN = 1'b0;
    end
  end

  // State, pc and pending redirect target
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      pend_pc   <= 32'h0000_0000;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (halt_req) begin
            state <= HALT;
          end else if (redirect) begin
            if (ihit) begin
              pc <= target;
            end else begin
              pend_pc   <= target;
              halt_pend <= 1'b0;
              state     <= DRAIN;
            end
          end else if (ihit && !stall) begin
            pc <= pc + PC_STRIDE;
          end else begin
            pc <= pc;
          end
        end
        // The wrong-path request stays on the bus until the icache answers it
        DRAIN: begin
          if (ihit) begin
            pc        <= drain_dest;
            halt_pend <= 1'b0;
            state     <= (halt_pend || halt_req) ? HALT : FETCH;
          end else begin
            pend_pc <= drain_dest;
            if (halt_req) begin
              halt_pend <= 1'b1;
            end else begin
              halt_pend <= halt_pend;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Delivered-instruction counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_count <= 32'h0000_0000;
    end else if (instr_valid) begin
      fetch_count <= sat_inc(fetch_count);
    end else begin
      fetch_count <= fetch_count;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, corner sequences, random run against a model.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, stall, halt_req, Branch, Jump, JR;
  logic [31:0] redir_npc, bimm, jraddr;
  logic [25:0] jimm;
  logic        imemREN, instr_valid, flush, halted;
  logic [31:0] imemaddr, npc, fetch_count;

  int checks = 0;
  int errors = 0;

  localparam int MF = 0, MD = 1, MH = 2;
  int          m_mode;
  logic [31:0] m_pc, m_pend, m_cnt;
  logic        m_hp, m_iv;

  fetch_sequencer dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt_req(halt_req),
    .Branch(Branch), .Jump(Jump), .JR(JR), .redir_npc(redir_npc), .bimm(bimm),
    .jimm(jimm), .jraddr(jraddr), .imemREN(imemREN), .imemaddr(imemaddr),
    .npc(npc), .instr_valid(instr_valid), .flush(flush), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_target();
    if (JR) return jraddr;
    if (Jump) return {redir_npc[31:28], jimm, 2'b00};
    return redir_npc + bimm * 32'd4;
  endfunction

  task automatic model_check();
    logic redir;
    redir = Branch | Jump | JR;
    m_iv  = (m_mode == MF) && !halt_req && !redir && ihit && !stall;
    chk("imemREN", {31'd0, imemREN}, {31'd0, m_mode != MH});
    chk("imemaddr", imemaddr, m_pc);
    chk("npc", npc, m_pc + 32'd4);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
    chk("flush", {31'd0, flush}, {31'd0, redir && (m_mode != MH)});
    chk("halted", {31'd0, halted}, {31'd0, m_mode == MH});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic model_update();
    logic        redir;
    logic [31:0] t;
    redir = Branch | Jump | JR;
    t     = m_target();
    if (m_iv && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    case (m_mode)
      MF: begin
        if (halt_req) m_mode = MH;
        else if (redir) begin
          if (ihit) m_pc = t;
          else begin m_pend = t; m_hp = 1'b0; m_mode = MD; end
        end else if (m_iv) m_pc = m_pc + 32'd4;
      end
      MD: begin
        if (redir) m_pend = t;
        if (halt_req) m_hp = 1'b1;
        if (ihit) begin m_pc = m_pend; m_mode = m_hp ? MH : MF; m_hp = 1'b0; end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic ih, st, hr, br, jp, jr_, input logic [31:0] rn, bi,
                      input logic [25:0] ji, input logic [31:0] ja);
    @(negedge CLK);
    ihit = ih; stall = st; halt_req = hr; Branch = br; Jump = jp; JR = jr_;
    redir_npc = rn; bimm = bi; jimm = ji; jraddr = ja;
    #1;
    model_check();
    model_update();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    ihit = 1'b1; Branch = 1'b1; stall = 1'b0; halt_req = 1'b0; Jump = 1'b0; JR = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_imemREN", {31'd0, imemREN}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge CLK);
    RST = 1'b0; ihit = 1'b0; Branch = 1'b0;
    m_mode = MF; m_pc = 32'h0; m_pend = 32'h0; m_hp = 1'b0; m_cnt = 32'h0;
    #1;
    chk("rst_pc", imemaddr, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
  endtask

  typedef struct {
    logic        ih, st, br;
    logic [31:0] rn, bi;
    logic [31:0] e_addr;
    logic        e_iv, e_fl;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    RST = 1'b0; ihit = 1'b0; stall = 1'b0; halt_req = 1'b0; Branch = 1'b0; Jump = 1'b0;
    JR = 1'b0; redir_npc = 32'h0; bimm = 32'h0; jimm = 26'h0; jraddr = 32'h0;
    m_mode = MF; m_pc = 32'h0; m_pend = 32'h0; m_hp = 1'b0; m_cnt = 32'h0; m_iv = 1'b0;

    //           ih    st    br    redir_npc      bimm           addr           iv    fl    count
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         1'b1, 1'b0, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h8,         1'b1, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'hC,         1'b1, 1'b0, 32'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h10,        1'b0, 1'b0, 32'd4};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h10,        1'b0, 1'b0, 32'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h10,        1'b0, 1'b0, 32'd4};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h10,        1'b1, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h20,        32'd3,         32'h14,        1'b0, 1'b1, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h14,        1'b0, 1'b0, 32'd5};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h14,        1'b0, 1'b0, 32'd5};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h2C,        1'b1, 1'b0, 32'd5};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h30,        1'b1, 1'b0, 32'd6};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h34,        1'b0, 1'b0, 32'd7};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h100,       32'hFFFF_FFFF, 32'h34,        1'b0, 1'b1, 32'd7};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'hFC,        1'b1, 1'b0, 32'd7};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h100,       1'b0, 1'b0, 32'd8};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].ih, vecs[i].st, 1'b0, vecs[i].br, 1'b0, 1'b0, vecs[i].rn, vecs[i].bi,
           26'h0, 32'h0);
      chk($sformatf("vec%0d_addr", i), imemaddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_iv", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_iv});
      chk($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_fl});
      chk($sformatf("vec%0d_count", i), fetch_count, vecs[i].e_cnt);
    end

    // Jump and JR together: JR target wins
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 26'h3FF, 32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("jr_priority_pc", imemaddr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 26'h10, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("jump_pc", imemaddr, 32'h1000_0040);

    // Redirect during drain, latest wins, then halt requested while draining
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'd1, 26'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'h0, 32'h300);
    chk("drain_addr_stable", imemaddr, 32'h1000_0040);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("drain_no_halt_yet", {31'd0, halted}, 32'd0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("post_reset_iv", {31'd0, instr_valid}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("post_reset_no_halt", {31'd0, halted}, 32'd0);
    chk("post_reset_pc", imemaddr, 32'h8);

    // Halt beats a simultaneous branch; pc stays frozen
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'd4, 26'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0, $urandom, $urandom,
           26'($urandom), $urandom);
      chk("halt_frozen_pc", imemaddr, 32'h8);
      chk("halt_ren", {31'd0, imemREN}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (($urandom_range(0, 299) == 0) || (m_mode == MH && $urandom_range(0, 29) == 0)) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0,
             $urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 14) == 0, $urandom_range(0, 19) == 0,
             $urandom, $urandom, 26'($urandom), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
